acc_cpu_p: RTL and testbench

ACC_CPU_P -- requirements
Module: acc_cpu_p

---
 rtl/acc_cpu_p.sv | 170 +++++++++++++++++
 tb/tb_acc_cpu_p.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_p.sv
// Accumulator CPU with a multi-cycle FSM and a req/ready memory port.
// One shared memory holds both instructions and data.
module acc_cpu_p #(
  parameter int DW  = 16,
  parameter int AW  = 8,
  parameter int OPW = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          halted,
  output logic          illegal,
  output logic [AW-1:0] pc_out,
  output logic [DW-1:0] acc_out
);

  localparam logic [2:0] S_FETCH    = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_EXEC_RD  = 3'd2;
  localparam logic [2:0] S_EXEC_ALU = 3'd3;
  localparam logic [2:0] S_EXEC_WR  = 3'd4;
  localparam logic [2:0] S_HALT     = 3'd5;

  localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
  localparam logic [OPW-1:0] OP_OR    = OPW'(2);
  localparam logic [OPW-1:0] OP_LOAD  = OPW'(3);
  localparam logic [OPW-1:0] OP_STORE = OPW'(4);
  localparam logic [OPW-1:0] OP_JUMP  = OPW'(5);
  localparam logic [OPW-1:0] OP_JUMPZ = OPW'(6);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(7);
  localparam logic [OPW-1:0] OP_AND   = OPW'(8);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(9);
  localparam logic [OPW-1:0] OP_JUMPC = OPW'(10);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(11);

  logic [2:0]    state_reg;
  logic [AW-1:0] pc_reg;
  logic [DW-1:0] ir_reg;
  logic [DW-1:0] acc_reg;
  logic [DW-1:0] operand_reg;
  logic          zflag_reg;
  logic          cflag_reg;
  logic          illegal_reg;

  logic [OPW-1:0] opcode;
  logic [AW-1:0]  addr_a;
  logic           is_read_op;
  logic [DW-1:0]  alu_result;
  logic           alu_carry;
  logic           alu_sets_carry;
  logic [DW:0]    sum_wide;

  assign opcode = ir_reg[OPW-1:0];
  assign addr_a = ir_reg[DW-1:DW-AW];

  // Every instruction that needs an operand fetched before the ALU cycle.
  always_comb begin
    is_read_op = 1'b0;
    case (opcode)
      OP_ADD, OP_OR, OP_LOAD, OP_SUB, OP_AND, OP_XOR: is_read_op = 1'b1;
      default:                                        is_read_op = 1'b0;
    endcase
  end

  always_comb begin
    sum_wide       = {1'b0, acc_reg} + {1'b0, operand_reg};
    alu_result     = operand_reg;
    alu_carry      = cflag_reg;
    alu_sets_carry = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_result     = sum_wide[DW-1:0];
        alu_carry      = sum_wide[DW];
        alu_sets_carry = 1'b1;
      end
      OP_SUB: begin
        alu_result     = acc_reg - operand_reg;
        alu_carry      = (acc_reg < operand_reg);
        alu_sets_carry = 1'b1;
      end
      OP_OR:   alu_result = acc_reg | operand_reg;
      OP_AND:  alu_result = acc_reg & operand_reg;
      OP_XOR:  alu_result = acc_reg ^ operand_reg;
      default: alu_result = operand_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      pc_reg      <= '0;
      ir_reg      <= '0;
      acc_reg     <= '0;
      operand_reg <= '0;
      zflag_reg   <= 1'b0;
      cflag_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (mem_ready) begin
            ir_reg    <= mem_rdata;
            pc_reg    <= pc_reg + 1'b1;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_read_op) begin
            state_reg <= S_EXEC_RD;
          end else begin
            case (opcode)
              OP_STORE: state_reg <= S_EXEC_WR;
              OP_JUMP: begin
                pc_reg    <= addr_a;
                state_reg <= S_FETCH;
              end
              OP_JUMPZ: begin
                if (zflag_reg) pc_reg <= addr_a;
                state_reg <= S_FETCH;
              end
              OP_JUMPC: begin
                if (cflag_reg) pc_reg <= addr_a;
                state_reg <= S_FETCH;
              end
              OP_HALT: state_reg <= S_HALT;
              default: begin
                illegal_reg <= 1'b1;
                state_reg   <= S_HALT;
              end
            endcase
          end
        end
        S_EXEC_RD: begin
          if (mem_ready) begin
            operand_reg <= mem_rdata;
            state_reg   <= S_EXEC_ALU;
          end
        end
        S_EXEC_ALU: begin
          acc_reg   <= alu_result;
          zflag_reg <= (alu_result == '0);
          if (alu_sets_carry) cflag_reg <= alu_carry;
          state_reg <= S_FETCH;
        end
        S_EXEC_WR: begin
          if (mem_ready) state_reg <= S_FETCH;
        end
        S_HALT:  state_reg <= S_HALT;
        default: state_reg <= S_HALT;
      endcase
    end
  end

  // Request lines are decoded from state, so they hold steady through wait cycles.
  assign mem_req   = !rst && ((state_reg == S_FETCH) || (state_reg == S_EXEC_RD) ||
                              (state_reg == S_EXEC_WR));
  assign mem_we    = !rst && (state_reg == S_EXEC_WR);
  assign mem_addr  = (state_reg == S_FETCH) ? pc_reg : addr_a;
  assign mem_wdata = acc_reg;
  assign halted    = !rst && (state_reg == S_HALT);
  assign illegal   = !rst && illegal_reg;
  assign pc_out    = pc_reg;
  assign acc_out   = acc_reg;

endmodule

// File: tb/tb_acc_cpu_p.sv
// Bench for acc_cpu_p: a wait-state memory responder plus an instruction-level
// reference interpreter that predicts final ACC/PC/memory and cycle counts.
module tb_acc_cpu_p;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, halted, illegal;
  logic [7:0]  mem_addr, pc_out;
  logic [15:0] mem_wdata, mem_rdata, acc_out;

  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  int          wait_cycles = 0;
  int          total = 0;
  int          bad = 0;
  int          last_cycles = 0;

  always #5 clk = ~clk;

  acc_cpu_p #(.DW(16), .AW(8), .OPW(8)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .illegal(illegal), .pc_out(pc_out), .acc_out(acc_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [7:0] a, input logic [7:0] op);
    return {a, op};
  endfunction

  // Memory responder: each access waits wait_cycles cycles, then completes.
  initial begin
    logic [7:0] lat_addr;
    logic       lat_we;
    bit         in_access;
    int         wcnt;
    in_access = 0;
    wcnt      = 0;
    lat_addr  = '0;
    lat_we    = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!mem_req) begin
        mem_ready = 1'b0;
        in_access = 0;
        wcnt      = 0;
      end else begin
        if (!in_access) begin
          in_access = 1;
          lat_addr  = mem_addr;
          lat_we    = mem_we;
          wcnt      = 0;
        end else begin
          chk("addr_stable", {24'b0, mem_addr}, {24'b0, lat_addr});
          chk("we_stable", {31'b0, mem_we}, {31'b0, lat_we});
        end
        if (wcnt < wait_cycles) begin
          mem_ready = 1'b0;
          mem_rdata = 16'($urandom);
          wcnt++;
        end else begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr];
          if (mem_we) mem[mem_addr] = mem_wdata;
          in_access = 0;
        end
      end
    end
  end

  // Instruction-level interpreter over ref_mem.
  task automatic model(output logic [15:0] e_acc, output logic [7:0] e_pc,
                       output logic e_ill, output int e_cyc);
    logic [15:0] acc, m, w;
    logic [16:0] wide;
    logic [7:0]  pc, op, a;
    bit          z, c;
    int          steps;
    acc = 0; pc = 0; z = 0; c = 0; steps = 0; e_ill = 0; e_cyc = 0;
    while (steps < 1000) begin
      w  = ref_mem[pc];
      pc = pc + 8'd1;
      op = w[7:0];
      a  = w[15:8];
      steps++;
      if (op inside {8'd1, 8'd2, 8'd3, 8'd7, 8'd8, 8'd9}) begin
        m = ref_mem[a];
        e_cyc += 4 + 2 * wait_cycles;
        case (op)
          8'd1: begin wide = {1'b0, acc} + {1'b0, m}; acc = wide[15:0]; c = wide[16]; end
          8'd7: begin c = (acc < m); acc = acc - m; end
          8'd2: acc = acc | m;
          8'd8: acc = acc & m;
          8'd9: acc = acc ^ m;
          default: acc = m;
        endcase
        z = (acc == 0);
      end else if (op == 8'd4) begin
        ref_mem[a] = acc;
        e_cyc += 3 + 2 * wait_cycles;
      end else begin
        e_cyc += 2 + wait_cycles;
        if (op == 8'd5) pc = a;
        else if (op == 8'd6) begin if (z) pc = a; end
        else if (op == 8'd10) begin if (c) pc = a; end
        else begin
          e_ill = (op != 8'd11);
          break;
        end
      end
    end
    e_acc = acc;
    e_pc  = pc;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // Two reset edges, checks of reset outputs, then release on a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_rst_req"}, {31'b0, mem_req}, 32'd0);
    chk({tag, "_rst_halted"}, {31'b0, halted}, 32'd0);
    chk({tag, "_rst_illegal"}, {31'b0, illegal}, 32'd0);
    chk({tag, "_rst_pc"}, {24'b0, pc_out}, 32'd0);
    chk({tag, "_rst_acc"}, {16'b0, acc_out}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic run_prog(input string tag);
    logic [15:0] e_acc;
    logic [7:0]  e_pc;
    logic        e_ill;
    int          e_cyc, cyc;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    model(e_acc, e_pc, e_ill, e_cyc);
    do_reset(tag);
    cyc = 0;
    while (1) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (halted) break;
      if (cyc > 20000) begin
        chk({tag, "_timeout"}, 32'd0, 32'd1);
        break;
      end
    end
    last_cycles = cyc;
    chk({tag, "_cycles"}, cyc, e_cyc);
    chk({tag, "_acc"}, {16'b0, acc_out}, {16'b0, e_acc});
    chk({tag, "_pc"}, {24'b0, pc_out}, {24'b0, e_pc});
    chk({tag, "_illegal"}, {31'b0, illegal}, {31'b0, e_ill});
    repeat (2) @(negedge clk);
    chk({tag, "_halt_noreq"}, {31'b0, mem_req}, 32'd0);
    chk({tag, "_halt_stays"}, {31'b0, halted}, 32'd1);
    for (int i = 128; i < 144; i++)
      chk($sformatf("%s_mem%0h", tag, i), {16'b0, mem[i]}, {16'b0, ref_mem[i]});
  endtask

  task automatic gen_random(input int len);
    int r;
    logic [7:0] ops [6];
    ops = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd8, 8'd9};
    clear_mem();
    for (int i = 128; i < 144; i++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: mem[i] = 16'h0000;
        1: mem[i] = 16'h0001;
        2: mem[i] = 16'hFFFF;
        3: mem[i] = 16'h8000;
        default: mem[i] = 16'($urandom);
      endcase
    end
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) mem[i] = ins(8'(128 + $urandom_range(0, 15)), ops[$urandom_range(0, 5)]);
      else if (r == 6) mem[i] = ins(8'(128 + $urandom_range(0, 15)), 8'd4);
      else mem[i] = ins(8'($urandom_range(i + 1, len)), (r == 7) ? 8'd5 : (r == 8) ? 8'd6 : 8'd10);
    end
    if ($urandom_range(0, 3) == 0) mem[len] = ins(8'h00, 8'($urandom_range(12, 255)));
    else mem[len] = ins(8'h00, 8'd11);
  endtask

  initial begin
    int cyc;
    // Basic program, zero wait states
    wait_cycles = 0;
    clear_mem();
    mem[0] = ins(8'h0D, 8'd3); mem[1] = ins(8'h0E, 8'd1);
    mem[2] = ins(8'h0F, 8'd4); mem[3] = ins(8'h00, 8'd11);
    mem[13] = 16'h0005; mem[14] = 16'h0003;
    run_prog("basic");
    chk("basic_result", {16'b0, mem[15]}, 32'h0008);
    chk("basic_13cyc", last_cycles, 32'd13);
    $display("txn basic: cycles=%0d mem[0F]=%0h", last_cycles, mem[15]);

    // Same program with three wait cycles per access
    wait_cycles = 3;
    mem[15] = 16'h0000;
    run_prog("waits");
    chk("waits_result", {16'b0, mem[15]}, 32'h0008);
    $display("txn waits: cycles=%0d mem[0F]=%0h", last_cycles, mem[15]);

    // Carry out and zero, taken JUMPC then taken JUMPZ
    wait_cycles = 0;
    clear_mem();
    mem[0] = ins(8'h80, 8'd3); mem[1] = ins(8'h81, 8'd1);
    mem[2] = ins(8'h20, 8'd10); mem[3] = ins(8'h00, 8'd11);
    mem[8'h20] = ins(8'h30, 8'd6); mem[8'h21] = ins(8'h00, 8'd11);
    mem[8'h30] = ins(8'h00, 8'd11);
    mem[8'h80] = 16'hFFFF; mem[8'h81] = 16'h0001;
    run_prog("carry");
    chk("carry_pc", {24'b0, pc_out}, 32'h31);
    $display("txn carry: acc=%0h pc=%0h", acc_out, pc_out);

    // Borrow: JUMPZ not taken, JUMPC taken
    clear_mem();
    mem[0] = ins(8'h80, 8'd3); mem[1] = ins(8'h81, 8'd7);
    mem[2] = ins(8'h40, 8'd6); mem[3] = ins(8'h10, 8'd10);
    mem[4] = ins(8'h00, 8'd11);
    mem[8'h10] = ins(8'h82, 8'd4); mem[8'h11] = ins(8'h00, 8'd11);
    mem[8'h80] = 16'h0002; mem[8'h81] = 16'h0003;
    run_prog("borrow");
    chk("borrow_acc", {16'b0, acc_out}, 32'hFFFF);
    chk("borrow_store", {16'b0, mem[8'h82]}, 32'hFFFF);
    $display("txn borrow: acc=%0h pc=%0h", acc_out, pc_out);

    // Undefined opcode, then a reset pulse
    clear_mem();
    mem[0] = ins(8'h00, 8'h3F);
    run_prog("illegal");
    chk("illegal_flag", {31'b0, illegal}, 32'd1);
    do_reset("illegal_clr");
    #2;
    chk("illegal_refetch_req", {31'b0, mem_req}, 32'd1);
    chk("illegal_refetch_addr", {24'b0, mem_addr}, 32'd0);
    $display("txn illegal: cleared, refetch addr=%0h", mem_addr);

    // JUMP placed at the top address wraps PC
    clear_mem();
    mem[0] = ins(8'hFF, 8'd5); mem[8'hFF] = ins(8'h05, 8'd5);
    mem[5] = ins(8'h00, 8'd11);
    run_prog("wrap");
    chk("wrap_pc", {24'b0, pc_out}, 32'h06);
    $display("txn wrap: pc=%0h", pc_out);

    // Reset during a stalled store
    wait_cycles = 10;
    clear_mem();
    mem[0] = ins(8'h80, 8'd3); mem[1] = ins(8'h81, 8'd4);
    mem[8'h80] = 16'h1234;
    do_reset("abort");
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_wr", {31'b0, mem_req && mem_we}, 32'd1);
    chk("abort_acc_before", {16'b0, acc_out}, 32'h1234);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_acc", {16'b0, acc_out}, 32'd0);
    chk("abort_pc", {24'b0, pc_out}, 32'd0);
    chk("abort_noreq", {31'b0, mem_req}, 32'd0);
    rst = 1'b0;
    #2;
    chk("abort_refetch_addr", {24'b0, mem_addr}, 32'd0);
    chk("abort_refetch_we", {31'b0, mem_we}, 32'd0);
    $display("txn abort: acc=%0h refetch addr=%0h", acc_out, mem_addr);

    // Random forward-branching programs with random wait states
    for (int t = 0; t < 10; t++) begin
      wait_cycles = $urandom_range(0, 2);
      gen_random(24);
      run_prog($sformatf("rand%0d", t));
      $display("txn rand%0d: waits=%0d cycles=%0d acc=%0h pc=%0h ill=%0b",
               t, wait_cycles, last_cycles, acc_out, pc_out, illegal);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
